// File: rtl/dac_serial_tx.sv
// Serial transmitter feeding a 12-bit SPI-style DAC with a 16-bit SYNC_N-framed word.
// SCLK is divided from CLOCK and idles high. DIN changes on SCLK rising edges only.
module dac_serial_tx #(
    parameter int unsigned CLK_DIV    = 500,
    parameter logic [3:0]  CTRL_BITS  = 4'b0000,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [11:0] SAMPLE,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    output logic        DAC_SCLK,
    output logic        DAC_SYNC_N,
    output logic        DAC_DIN,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned SHIFT_W = 15;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_nxt;
    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] shift_nxt;

    logic sclk_nxt;
    logic sync_n_nxt;
    logic din_nxt;
    logic ready_nxt;
    logic busy_nxt;
    logic done_nxt;

    logic accept_c;
    logic div_tc_c;
    logic rise_c;
    logic last_rise_c;
    logic gap_end_c;

    // Frame-event decode shared by the next-state and output logic.
    assign accept_c    = (state == ST_IDLE) && SAMPLE_VALID && SAMPLE_READY;
    assign div_tc_c    = (div_cnt == DIV_LAST);
    assign rise_c      = (state == ST_SHIFT) && div_tc_c && !DAC_SCLK;
    assign last_rise_c = rise_c && (bit_cnt == '0);
    assign gap_end_c   = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept_c)    state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_rise_c) state_nxt = ST_GAP;
            ST_GAP:   if (gap_end_c)   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below.
    always_comb begin
        sclk_nxt    = DAC_SCLK;
        sync_n_nxt  = DAC_SYNC_N;
        din_nxt     = DAC_DIN;
        ready_nxt   = SAMPLE_READY;
        busy_nxt    = BUSY;
        done_nxt    = 1'b0;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        gap_cnt_nxt = gap_cnt;
        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                if (accept_c) begin
                    shift_nxt   = {CTRL_BITS[2:0], SAMPLE};
                    din_nxt     = CTRL_BITS[3];
                    ready_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                    sync_n_nxt  = 1'b0;
                    sclk_nxt    = 1'b1;
                    bit_cnt_nxt = BIT_TOP;
                    div_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                div_cnt_nxt = div_tc_c ? '0 : div_cnt + DIV_W'(1);
                if (div_tc_c) begin
                    sclk_nxt = ~DAC_SCLK;
                end
                // Falling edges only let the DAC sample; all data movement happens on rising edges.
                if (rise_c) begin
                    if (bit_cnt != '0) begin
                        bit_cnt_nxt = bit_cnt - BIT_W'(1);
                        din_nxt     = shift_reg[SHIFT_W-1];
                        shift_nxt   = {shift_reg[SHIFT_W-2:0], 1'b0};
                    end else begin
                        sync_n_nxt  = 1'b1;
                        din_nxt     = 1'b0;
                        done_nxt    = 1'b1;
                        gap_cnt_nxt = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end_c) begin
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            DAC_SCLK     <= 1'b1;
            DAC_SYNC_N   <= 1'b1;
            DAC_DIN      <= 1'b0;
            SAMPLE_READY <= 1'b0;
            BUSY         <= 1'b0;
            FRAME_DONE   <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            DAC_SCLK     <= sclk_nxt;
            DAC_SYNC_N   <= sync_n_nxt;
            DAC_DIN      <= din_nxt;
            SAMPLE_READY <= ready_nxt;
            BUSY         <= busy_nxt;
            FRAME_DONE   <= done_nxt;
            shift_reg    <= shift_nxt;
            bit_cnt      <= bit_cnt_nxt;
            div_cnt      <= div_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: three instances (CLK_DIV 2, 1, 500) behind a selector.
// Outputs are sampled and inputs driven on the falling CLOCK edge.
module tb_dac_serial_tx;

    logic        CLOCK   = 1'b0;
    logic        RESET_N = 1'b0;
    logic [11:0] sample  = 12'h000;
    logic        valid   = 1'b0;
    logic [1:0]  sel     = 2'd0;
    int          cyc     = 0;
    int          total   = 0;
    int          bad     = 0;

    logic [2:0] rdy, sclk, sync_n, din, busy, fd;
    logic mon_ready, mon_sclk, mon_sync_n, mon_din, mon_busy, mon_fd;

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    assign mon_ready  = rdy[sel];
    assign mon_sclk   = sclk[sel];
    assign mon_sync_n = sync_n[sel];
    assign mon_din    = din[sel];
    assign mon_busy   = busy[sel];
    assign mon_fd     = fd[sel];

    dac_serial_tx #(.CLK_DIV(2), .CTRL_BITS(4'b0000), .GAP_CYCLES(4)) u_div2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SAMPLE(sample), .SAMPLE_VALID(valid && (sel == 2'd0)),
        .SAMPLE_READY(rdy[0]), .DAC_SCLK(sclk[0]), .DAC_SYNC_N(sync_n[0]), .DAC_DIN(din[0]),
        .BUSY(busy[0]), .FRAME_DONE(fd[0]));

    dac_serial_tx #(.CLK_DIV(1), .CTRL_BITS(4'b0000), .GAP_CYCLES(4)) u_div1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SAMPLE(sample), .SAMPLE_VALID(valid && (sel == 2'd1)),
        .SAMPLE_READY(rdy[1]), .DAC_SCLK(sclk[1]), .DAC_SYNC_N(sync_n[1]), .DAC_DIN(din[1]),
        .BUSY(busy[1]), .FRAME_DONE(fd[1]));

    dac_serial_tx #(.CLK_DIV(500), .CTRL_BITS(4'b0000), .GAP_CYCLES(4)) u_div500 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SAMPLE(sample), .SAMPLE_VALID(valid && (sel == 2'd2)),
        .SAMPLE_READY(rdy[2]), .DAC_SCLK(sclk[2]), .DAC_SYNC_N(sync_n[2]), .DAC_DIN(din[2]),
        .BUSY(busy[2]), .FRAME_DONE(fd[2]));

    typedef struct {
        logic [15:0] bits;
        int nfall, low, fd, fd_at_rise, gap, ready_after, start, per, din_hi;
        int timeout, ready_at_start, busy_at_start, ready_at_poke;
    } cap_t;

    // Observe one frame of the selected instance: waits for SYNC_N low, runs through the gap.
    task automatic capture_frame(input int budget, input bit clr_valid, input int poke_at,
                                 output cap_t c);
        int  n  = 0;
        int  f1 = -1;
        int  f2 = -1;
        logic ps;
        c = '{default: 0};
        while (mon_sync_n !== 1'b0 && n < budget) begin
            @(negedge CLOCK); n++;
        end
        if (n >= budget) begin
            c.timeout = 1;
            return;
        end
        if (clr_valid) valid = 1'b0;
        c.start = cyc;
        c.ready_at_start = int'(mon_ready);
        c.busy_at_start  = int'(mon_busy);
        ps = 1'b1;
        while (mon_sync_n === 1'b0 && n < budget) begin
            if (c.low == poke_at) begin
                c.ready_at_poke = int'(mon_ready);
                sample = 12'h123;
                valid  = 1'b1;
            end
            if (poke_at >= 0 && c.low == poke_at + 1) begin
                valid  = 1'b0;
                sample = 12'hFFF;
            end
            c.low++;
            if (mon_din === 1'b1) c.din_hi++;
            if (mon_fd === 1'b1) c.fd++;
            if (ps === 1'b1 && mon_sclk === 1'b0) begin
                c.bits = {c.bits[14:0], mon_din};
                c.nfall++;
                if (f1 < 0) f1 = cyc;
                else if (f2 < 0) f2 = cyc;
            end
            ps = mon_sclk;
            @(negedge CLOCK); n++;
        end
        c.fd_at_rise = int'(mon_fd);
        if (mon_fd === 1'b1) c.fd++;
        while (mon_busy === 1'b1 && n < budget) begin
            c.gap++;
            @(negedge CLOCK); n++;
            if (mon_fd === 1'b1) c.fd++;
        end
        c.ready_after = int'(mon_ready);
        c.per = f2 - f1;
        if (n >= budget) c.timeout = 1;
    endtask

    task automatic test_reset();
        sel = 2'd0; valid = 1'b0; sample = 12'h000; RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK);
        total++; if (mon_sclk !== 1'b1)   begin bad++; $display("FAIL rst_sclk got=%b exp=1", mon_sclk); end
        total++; if (mon_sync_n !== 1'b1) begin bad++; $display("FAIL rst_sync_n got=%b exp=1", mon_sync_n); end
        total++; if (mon_din !== 1'b0)    begin bad++; $display("FAIL rst_din got=%b exp=0", mon_din); end
        total++; if (mon_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%b exp=0", mon_ready); end
        total++; if (mon_busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", mon_busy); end
        total++; if (mon_fd !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b exp=0", mon_fd); end
        RESET_N = 1'b1;
        @(negedge CLOCK);
        total++; if (mon_ready !== 1'b1)  begin bad++; $display("FAIL ready_after_release got=%b exp=1", mon_ready); end
        repeat (3) @(negedge CLOCK);
        total++; if ({mon_sclk, mon_sync_n, mon_din, mon_busy, mon_ready} !== 5'b11001)
            begin bad++; $display("FAIL idle_outputs got=%b exp=11001", {mon_sclk, mon_sync_n, mon_din, mon_busy, mon_ready}); end
    endtask

    task automatic test_single_frame();
        cap_t c;
        sel = 2'd0; sample = 12'hA5C; valid = 1'b1;
        capture_frame(300, 1'b1, -1, c);
        total++; if (c.timeout != 0)        begin bad++; $display("FAIL single_timeout got=%0d exp=0", c.timeout); end
        total++; if (c.ready_at_start != 0) begin bad++; $display("FAIL single_ready_on_accept got=%0d exp=0", c.ready_at_start); end
        total++; if (c.busy_at_start != 1)  begin bad++; $display("FAIL single_busy_on_accept got=%0d exp=1", c.busy_at_start); end
        total++; if (c.low != 64)           begin bad++; $display("FAIL single_sync_low got=%0d exp=64", c.low); end
        total++; if (c.bits !== 16'h0A5C)   begin bad++; $display("FAIL single_bits got=%h exp=0a5c", c.bits); end
        total++; if (c.nfall != 16)         begin bad++; $display("FAIL single_falls got=%0d exp=16", c.nfall); end
        total++; if (c.per != 4)            begin bad++; $display("FAIL single_sclk_period got=%0d exp=4", c.per); end
        total++; if (c.fd != 1)             begin bad++; $display("FAIL single_done_width got=%0d exp=1", c.fd); end
        total++; if (c.fd_at_rise != 1)     begin bad++; $display("FAIL single_done_at_sync_rise got=%0d exp=1", c.fd_at_rise); end
        total++; if (c.gap != 4)            begin bad++; $display("FAIL single_gap got=%0d exp=4", c.gap); end
        total++; if (c.ready_after != 1)    begin bad++; $display("FAIL single_ready_after_gap got=%0d exp=1", c.ready_after); end
    endtask

    task automatic test_back_to_back();
        cap_t c1, c2;
        sel = 2'd0; sample = 12'hFFF; valid = 1'b1;
        capture_frame(300, 1'b0, -1, c1);
        sample = 12'h000;
        capture_frame(300, 1'b1, -1, c2);
        total++; if (c1.timeout + c2.timeout != 0) begin bad++; $display("FAIL b2b_timeout got=%0d exp=0", c1.timeout + c2.timeout); end
        total++; if (c1.bits !== 16'h0FFF)  begin bad++; $display("FAIL b2b_bits1 got=%h exp=0fff", c1.bits); end
        total++; if (c2.bits !== 16'h0000)  begin bad++; $display("FAIL b2b_bits2 got=%h exp=0000", c2.bits); end
        total++; if (c2.nfall != 16)        begin bad++; $display("FAIL b2b_falls2 got=%0d exp=16", c2.nfall); end
        total++; if (c1.gap != 4)           begin bad++; $display("FAIL b2b_gap got=%0d exp=4", c1.gap); end
        total++; if (c2.start - c1.start != 69)
            begin bad++; $display("FAIL b2b_accept_spacing got=%0d exp=69", c2.start - c1.start); end
    endtask

    task automatic test_ignored_request();
        cap_t c;
        int   extra = 0;
        sel = 2'd0; sample = 12'h3C6; valid = 1'b1;
        capture_frame(300, 1'b1, 10, c);
        total++; if (c.timeout != 0)        begin bad++; $display("FAIL ign_timeout got=%0d exp=0", c.timeout); end
        total++; if (c.ready_at_poke != 0)  begin bad++; $display("FAIL ign_ready_mid_frame got=%0d exp=0", c.ready_at_poke); end
        total++; if (c.bits !== 16'h03C6)   begin bad++; $display("FAIL ign_bits got=%h exp=03c6", c.bits); end
        total++; if (c.low != 64)           begin bad++; $display("FAIL ign_sync_low got=%0d exp=64", c.low); end
        repeat (150) begin
            @(negedge CLOCK);
            if (mon_sync_n !== 1'b1 || mon_busy !== 1'b0) extra++;
        end
        total++; if (extra != 0)            begin bad++; $display("FAIL ign_second_frame got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_frame();
        cap_t c;
        int   n = 0;
        int   falls = 0;
        int   dones = 0;
        logic ps = 1'b1;
        sel = 2'd0; sample = 12'hF0F; valid = 1'b1;
        while (mon_sync_n !== 1'b0 && n < 20) begin @(negedge CLOCK); n++; end
        valid = 1'b0;
        while (falls < 5 && n < 200) begin
            if (ps === 1'b1 && mon_sclk === 1'b0) falls++;
            ps = mon_sclk;
            if (falls < 5) begin @(negedge CLOCK); n++; end
        end
        total++; if ({falls, mon_sync_n, mon_din} != {32'd5, 1'b0, 1'b1})
            begin bad++; $display("FAIL mid_setup got falls=%0d sync_n=%b din=%b exp 5/0/1", falls, mon_sync_n, mon_din); end
        RESET_N = 1'b0;
        #1;
        total++; if ({mon_sync_n, mon_sclk, mon_din} !== 3'b110)
            begin bad++; $display("FAIL mid_async_reset got=%b exp=110", {mon_sync_n, mon_sclk, mon_din}); end
        total++; if ({mon_busy, mon_ready} !== 2'b00)
            begin bad++; $display("FAIL mid_reset_flags got=%b exp=00", {mon_busy, mon_ready}); end
        repeat (3) begin @(negedge CLOCK); if (mon_fd !== 1'b0) dones++; end
        RESET_N = 1'b1;
        repeat (5) begin @(negedge CLOCK); if (mon_fd !== 1'b0 || mon_sync_n !== 1'b1) dones++; end
        total++; if (dones != 0)            begin bad++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
        sample = 12'h800; valid = 1'b1;
        capture_frame(300, 1'b1, -1, c);
        total++; if (c.bits !== 16'h0800)   begin bad++; $display("FAIL mid_new_bits got=%h exp=0800", c.bits); end
        total++; if (c.nfall != 16)         begin bad++; $display("FAIL mid_new_falls got=%0d exp=16", c.nfall); end
        total++; if (c.fd != 1)             begin bad++; $display("FAIL mid_new_done got=%0d exp=1", c.fd); end
    endtask

    task automatic test_divider_extremes();
        cap_t c;
        sel = 2'd1; sample = 12'h001; valid = 1'b1;
        capture_frame(200, 1'b1, -1, c);
        total++; if (c.timeout != 0)        begin bad++; $display("FAIL div1_timeout got=%0d exp=0", c.timeout); end
        total++; if (c.bits !== 16'h0001)   begin bad++; $display("FAIL div1_bits got=%h exp=0001", c.bits); end
        total++; if (c.per != 2)            begin bad++; $display("FAIL div1_period got=%0d exp=2", c.per); end
        total++; if (c.low != 32)           begin bad++; $display("FAIL div1_sync_low got=%0d exp=32", c.low); end
        total++; if (c.din_hi != 2)         begin bad++; $display("FAIL div1_din_high got=%0d exp=2", c.din_hi); end
        total++; if (c.gap != 4)            begin bad++; $display("FAIL div1_gap got=%0d exp=4", c.gap); end
        sel = 2'd2; sample = 12'h001; valid = 1'b1;
        capture_frame(20000, 1'b1, -1, c);
        total++; if (c.timeout != 0)        begin bad++; $display("FAIL div500_timeout got=%0d exp=0", c.timeout); end
        total++; if (c.bits !== 16'h0001)   begin bad++; $display("FAIL div500_bits got=%h exp=0001", c.bits); end
        total++; if (c.per != 1000)         begin bad++; $display("FAIL div500_period got=%0d exp=1000", c.per); end
        total++; if (c.low != 16000)        begin bad++; $display("FAIL div500_sync_low got=%0d exp=16000", c.low); end
        total++; if (c.din_hi != 1000)      begin bad++; $display("FAIL div500_din_high got=%0d exp=1000", c.din_hi); end
        total++; if (c.fd != 1)             begin bad++; $display("FAIL div500_done got=%0d exp=1", c.fd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        test_divider_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
- Serial transmitter that sends parallel waveform samples to an external 12-bit SPI-style DAC (16-bit frame, SYNC_N framed, data sampled by the DAC on falling SCLK).
- Generates its own DAC serial clock by dividing CLOCK.
- Sits between the waveform sample generator (producer, valid/ready handshake) and the DAC pins.
- One frame per accepted sample.

Parameters:
- CLK_DIV, 500, CLOCK cycles per SCLK half-period; legal range is 1 or more.
- CTRL_BITS, 4'b0000, the 4 MSBs of every frame (DAC power-down/mode field).
- GAP_CYCLES, 4, CLOCK cycles SYNC_N is held high between frames; legal range is 1 or more.

Ports:
- CLOCK  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- SAMPLE  input  12  unsigned sample to convert.
- SAMPLE_VALID  input  1  producer has a sample on SAMPLE.
- SAMPLE_READY  output  1  block can accept a sample this cycle.
- DAC_SCLK  output  1  serial clock to the DAC; idles high.
- DAC_SYNC_N  output  1  frame select, active low.
- DAC_DIN  output  1  serial data, MSB first.
- BUSY  output  1  high from accept until the end of the gap.
- FRAME_DONE  output  1  one-cycle pulse at frame end.

Behaviour:
- Clock and reset: every register is clocked on the posedge of CLOCK. All outputs are registered.
- Reset values (asynchronous, while RESET_N=0):
  - DAC_SCLK=1, DAC_SYNC_N=1, DAC_DIN=0.
  - SAMPLE_READY=0, BUSY=0, FRAME_DONE=0.
  - State=IDLE, all counters 0.
- After reset release: SAMPLE_READY goes to 1 on the first clock edge.
- Reset asserted mid-frame: the frame is aborted immediately and the outputs take their reset values. No FRAME_DONE is generated. There is no partial resume.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - SAMPLE_READY=1.
  - On a CLOCK edge with SAMPLE_VALID=1 the block latches shift word = {CTRL_BITS, SAMPLE}.
  - On that same edge: SAMPLE_READY becomes 0, BUSY becomes 1, DAC_SYNC_N becomes 0, DAC_DIN becomes bit 15, DAC_SCLK stays 1, bit counter is set to 15, divide counter is cleared, and the state moves to SHIFT.
  - Latency from the accept edge to SYNC_N low is one edge; there is no extra cycle.
- SHIFT:
  - The divide counter runs 0..CLK_DIV-1. At terminal count it wraps to 0 and DAC_SCLK toggles.
  - High-to-low toggle: the DAC samples DAC_DIN. The block changes nothing else.
  - Low-to-high toggle:
    - If bit counter > 0: decrement it and drive DAC_DIN with the next lower bit.
    - If bit counter = 0: the 16th falling edge has already occurred. DAC_SYNC_N becomes 1, DAC_DIN becomes 0, FRAME_DONE pulses for this one cycle, and the state moves to GAP.
  - DAC_DIN is stable for exactly 2*CLK_DIV CLOCK cycles per bit. It changes only on SCLK rising, giving a half-period setup and hold around each falling edge.
  - SYNC_N is low for exactly 32*CLK_DIV CLOCK cycles (16 falling edges).
- GAP:
  - SYNC_N stays high for GAP_CYCLES cycles, then the state moves to IDLE.
  - BUSY falls and SAMPLE_READY rises on the same edge.
  - Accept-to-accept minimum spacing is 32*CLK_DIV + GAP_CYCLES + 1 cycles.
- Handshake:
  - A transfer occurs only when SAMPLE_VALID and SAMPLE_READY are both 1 on an edge.
  - SAMPLE_VALID while READY=0 is ignored and not queued; the producer must hold it.
  - SAMPLE changes after acceptance have no effect on the frame in flight.
- Counter widths: the divide counter is clog2(CLK_DIV) bits, minimum 1. The bit counter is 4 bits. No wrap occurs beyond the defined ranges.
- CLK_DIV=1: SCLK toggles every CLOCK cycle and the same rules apply.

Test Plan:
1. Reset and idle (CLK_DIV=2): hold RESET_N=0, then release it.
   - During reset: SCLK=1, SYNC_N=1, DIN=0, READY=0.
   - One edge after release: READY=1, and the outputs stay idle while SAMPLE_VALID=0.
2. Single frame (CLK_DIV=2, CTRL_BITS=0, SAMPLE=12'hA5C):
   - SYNC_N falls on the accept edge and stays low for 64 cycles.
   - Bits captured on the 16 SCLK falling edges are 16'h0A5C.
   - FRAME_DONE is one cycle wide, coincident with SYNC_N rise.
   - BUSY stays high a further 4 cycles, then READY=1.
3. Back-to-back (CLK_DIV=2, GAP_CYCLES=4): SAMPLE_VALID held at 1 with 12'hFFF, then 12'h000.
   - Two frames are sent: 16'h0FFF, then 16'h0000.
   - SYNC_N is high for exactly 4 cycles between them.
   - Accept edges are 69 cycles apart.
4. Ignored request: pulse SAMPLE_VALID with 12'h123 mid-frame while READY=0, then change SAMPLE.
   - The in-flight frame is unchanged.
   - No second frame is sent.
5. Reset mid-frame: assert RESET_N=0 after the 5th falling SCLK edge.
   - SYNC_N=1, SCLK=1 and DIN=0 immediately (asynchronously).
   - No FRAME_DONE.
   - After release, a new sample 12'h800 transmits as a full 16'h0800 frame.
6. Divider extremes: run CLK_DIV=1 and CLK_DIV=500 with SAMPLE=12'h001.
   - SCLK period is 2 and 1000 CLOCK cycles respectively.
   - DIN is high only during the 16th bit.
   - SYNC_N is low for 32 and 16000 cycles respectively.
